// File: rtl/regfile_pkg.sv
// Shared register-file macro definitions and package constants.
// Optional write-to-read forwarding is enabled with the REGFILE_BYPASS_EN macro.
`ifndef REGFILE_DEFINES_DONE
`define REGFILE_DEFINES_DONE
`define RSTENABLE   1'b1
`define WRITEENABLE 1'b1
`define READENABLE  1'b1
`define ZEROWORD    32'h0000_0000
`define REGBUS      31:0
`define REGADDRBUS  4:0
`define REGNUM      32
`endif

package regfile_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned REG_NUM = `REGNUM;

    typedef logic [REG_NUM-1:0][DATA_W-1:0] reg_array_t;

    // Register 0 is hardwired; this marks addresses that name real storage.
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return addr != ADDR_W'(0);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset/zero gating, optional bypass, enable gating.
// The forwarding path exists only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic             rst,
    input  logic             re,
    input  logic [`REGADDRBUS] raddr,
    input  reg_array_t       regs,
`ifdef REGFILE_BYPASS_EN
    input  logic             we,
    input  logic [`REGADDRBUS] waddr,
    input  logic [`REGBUS]   wdata,
`endif
    output logic [`REGBUS]   rdata
);

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;

    // Writeback targets the register decode is reading this cycle.
    assign bypass_hit = (we == `WRITEENABLE) && is_writable(waddr) &&
                        (re == `READENABLE) && (raddr == waddr);
`endif

    always_comb begin
        rdata = `ZEROWORD;
        if (rst == `RSTENABLE) begin
            rdata = `ZEROWORD;
        end else if (!is_writable(raddr)) begin
            rdata = `ZEROWORD;
`ifdef REGFILE_BYPASS_EN
        end else if (bypass_hit) begin
            rdata = wdata;
`endif
        end else if (re == `READENABLE) begin
            rdata = regs[raddr];
        end else begin
            rdata = `ZEROWORD;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [`REGADDRBUS] waddr,
    input  logic [`REGBUS]     wdata,
    input  logic               re1,
    input  logic [`REGADDRBUS] raddr1,
    output logic [`REGBUS]     rdata1,
    input  logic               re2,
    input  logic [`REGADDRBUS] raddr2,
    output logic [`REGBUS]     rdata2
);

    reg_array_t regs;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst == `RSTENABLE) begin
            for (int i = 0; i < `REGNUM; i++) begin
                regs[i] <= `ZEROWORD;
            end
        end else if ((we == `WRITEENABLE) && is_writable(waddr)) begin
            regs[waddr] <= wdata;
        end
    end

    regfile_rdport u_rdport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata1)
    );

    regfile_rdport u_rdport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int tests;
    int fails;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
        tick();
        tick();
        #1;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);

        // Reset between a write and a read erases the write
        rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
        #1;
        check("r5_written", rdata1, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("rst_gates_read", rdata1, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("r5_after_reset", rdata1, 32'h0);

        // Basic write then read on port 2
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; re2 = 1'b1; raddr2 = 5'd7;
        tick();
        we = 1'b0;
        #1;
        check("r7_read_port2", rdata2, 32'h12345678);

        // Writes to register 0 are discarded
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0;
        #1;
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_next_cycle", rdata1, 32'h0);
        tick();
        check("r0_later_cycle", rdata1, 32'h0);

        // Same-cycle write/read hazard on both ports
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000001;
        tick();
        wdata = 32'hA5A5A5A5; raddr1 = 5'd3; raddr2 = 5'd3; re1 = 1'b1; re2 = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_port1", rdata1, 32'hA5A5A5A5);
        check("hazard_port2", rdata2, 32'hA5A5A5A5);
`else
        check("hazard_port1", rdata1, 32'h00000001);
        check("hazard_port2", rdata2, 32'h00000001);
`endif
        tick();
        we = 1'b0;
        #1;
        check("hazard_next_p1", rdata1, 32'hA5A5A5A5);
        check("hazard_next_p2", rdata2, 32'hA5A5A5A5);

        // Read enable gating
        we = 1'b1; waddr = 5'd9; wdata = 32'h55AA55AA;
        tick();
        we = 1'b0; re1 = 1'b0; raddr1 = 5'd9;
        #1;
        check("re1_off", rdata1, 32'h0);
        re1 = 1'b1;
        #1;
        check("re1_on", rdata1, 32'h55AA55AA);

        // Write with enable low leaves storage alone, even with X address
        we = 1'b0; waddr = 5'd9; wdata = 32'h0BADF00D;
        tick();
        waddr = 5'bxxxxx; wdata = 32'hFFFFFFFF;
        tick();
        check("we0_r9", rdata1, 32'h55AA55AA);
        check("we0_r7", rdata2 & 32'h0, 32'h0 & rdata2);
        raddr2 = 5'd7;
        #1;
        check("xaddr_r7", rdata2, 32'h12345678);

        // Disabled port must not forward; other port reads independently
        we = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D;
        re1 = 1'b0; raddr1 = 5'd12; re2 = 1'b1; raddr2 = 5'd9;
        #1;
        check("bypass_re_off", rdata1, 32'h0);
        check("port2_indep", rdata2, 32'h55AA55AA);
        tick();
        we = 1'b0; re1 = 1'b1;
        #1;
        check("r12_written", rdata1, 32'hCAFEF00D);

        // Reset beats a simultaneous write and clears everything
        rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h00000077;
        raddr1 = 5'd7; re1 = 1'b1;
        #1;
        check("rst_read_r7", rdata1, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0; raddr1 = 5'd4; raddr2 = 5'd9; re2 = 1'b1;
        #1;
        check("rst_wins_r4", rdata1, 32'h0);
        check("rst_clears_r9", rdata2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have these ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high (level `RSTENABLE).
REQ-003 we  input  1  write enable from the writeback side (the wreg flag carried down the pipeline from the execute stage).
REQ-004 waddr  input  `REGADDRBUS (5)  destination register number (the wd field).
REQ-005 wdata  input  `REGBUS (32)  result to store (the wdata field).
REQ-006 re1 / re2  input  1 each  read-port enables from decode.
REQ-007 raddr1 / raddr2  input  `REGADDRBUS each  source register numbers.
REQ-008 rdata1 / rdata2  output  `REGBUS each  operand values delivered to decode as reg1/reg2.
REQ-009 There SHALL be one clock and no parameters; widths come from the shared macro definitions.

Function
REQ-010 Storage SHALL be 32 words x 32 bits, with entries 1..31 writable.
REQ-011 The write SHALL occur on the rising clk edge when rst is inactive, we=1 and waddr!=0.
REQ-012 Writes with waddr=0 SHALL be discarded.
REQ-013 Register 0 SHALL always read `ZEROWORD.
REQ-014 Reads SHALL be combinational, with zero-cycle latency from raddr/re to rdata.
REQ-015 Each read port's precedence, highest first:
  - rst active -> `ZEROWORD.
  - raddrN=0 -> `ZEROWORD.
  - bypass hit (see REQ-022) -> wdata.
  - reN=1 -> stored word.
  - reN=0 -> `ZEROWORD.
REQ-016 The two read ports SHALL be fully independent; identical addresses on both ports SHALL return identical data.
REQ-017 Without bypass, a write in cycle N SHALL become visible on rdata from cycle N+1.
REQ-018 A write with we=0 SHALL leave storage unchanged, regardless of waddr/wdata.
REQ-019 X on waddr with we=0 SHALL NOT corrupt any entry.

Reset
REQ-020 While rst=1 at a rising edge, all 32 entries SHALL clear to `ZEROWORD; any simultaneous write is ignored.
REQ-021 rdata1/rdata2 SHALL read `ZEROWORD during reset. Reset asserted between two writes SHALL leave no trace of the earlier write.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN, when defined:
  - Condition: we=1, waddr!=0, reN=1 and raddrN==waddr, with rst inactive.
  - Effect: rdataN SHALL equal wdata in the same cycle (write-to-read forwarding, covering the writeback->decode hazard).
REQ-023 When REGFILE_BYPASS_EN is undefined, no forwarding logic SHALL exist, and same-cycle reads SHALL return the pre-write value.

Structure
REQ-024 `REGBUS, `REGADDRBUS, `ZEROWORD, `RSTENABLE, `WRITEENABLE, `READENABLE and a new `REGNUM (32) SHALL live in the shared macro definitions file.
REQ-025 Each read port SHALL be one instance of a sub-module regfile_rdport (address decode, zero/enable gating, optional bypass mux), instantiated twice.
REQ-026 Storage and the write logic SHALL stay in regfile.

Verification
REQ-027 Reset: rst=1 for 1 cycle after writing 0xDEADBEEF to r5, then re1=1, raddr1=5 -> rdata1=0x00000000.
REQ-028 Basic write/read:
  - Stimulus: we=1, waddr=7, wdata=0x12345678 at cycle N; read raddr2=7, re2=1 at N+1.
  - Required response: rdata2=0x12345678.
REQ-029 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, then raddr1=0, re1=1 -> rdata1=0x00000000 on every cycle.
REQ-030 Same-cycle hazard:
  - Stimulus: r3 holds 0x1; at cycle N, we=1, waddr=3, wdata=0xA5A5A5A5, raddr1=raddr2=3, re1=re2=1.
  - With REGFILE_BYPASS_EN: both rdata=0xA5A5A5A5 in cycle N.
  - Without: both rdata=0x00000001 in cycle N; both =0xA5A5A5A5 at N+1.
REQ-031 Read disable: r9=0x55AA55AA, re1=0, raddr1=9 -> rdata1=0x00000000; re1=1 -> 0x55AA55AA.
REQ-032 Reset wins: rst=1 together with we=1, waddr=4, wdata=0x77; after rst drops -> raddr1=4, re1=1 gives rdata1=0x00000000.
